// File: rtl/freq_pkg.sv
// Shared definitions for the frequency meter.
//   HP_W_DEFAULT   : default width of the half-period code
//   HP_MAX_DEFAULT : largest half-period code at the default width
//   MATCH_W        : width of the consecutive-capture match counter
//   state_e        : measurement FSM states
//   sat_inc        : saturating increment for the match counter
package freq_pkg;

  localparam int unsigned HP_W_DEFAULT   = 7;
  localparam int unsigned HP_MAX_DEFAULT = (1 << HP_W_DEFAULT) - 1;

  // Wide enough for LOCK_COUNT up to 15.
  localparam int unsigned MATCH_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2
  } state_e;

  function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] v);
    return (v == {MATCH_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Front end of the frequency meter: synchronizes an asynchronous square wave
// into synth_clk, optionally deglitches it, and emits a registered one-cycle
// pulse on every level change (rising or falling).
// Optional feature macro: FREQ_METER_DEGLITCH_EN (adds the deglitch stage).
// Ports:
//   synth_clk  : clock
//   rst_n      : asynchronous active-low reset
//   clr        : synchronous clear of every flop
//   din        : asynchronous input level
//   edge_pulse : one-cycle pulse per accepted level change
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic synth_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level;
  logic                   hist_q;
  logic                   edge_q;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

`ifdef FREQ_METER_DEGLITCH_EN
  logic dly_q;
  logic lvl_q;

  // A new level is taken once two consecutive synced samples agree; a level
  // that lasts a single cycle never reaches the history flop.
  assign level = (synced == dly_q) ? synced : lvl_q;

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= 1'b0;
      lvl_q <= 1'b0;
    end else if (clr) begin
      dly_q <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      dly_q <= synced;
      lvl_q <= level;
    end
  end
`else
  assign level = synced;
`endif

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else if (clr) begin
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      hist_q <= level;
      edge_q <= level ^ hist_q;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/freq_meter.sv
// Measures the half-period of an incoming square wave in synth_clk cycles and
// reports it with the same code the tone generator consumes (hp=N reads N).
// Optional feature macro: FREQ_METER_DEGLITCH_EN (deglitch stage in the front end).
// Ports:
//   synth_clk  : clock
//   rst_n      : asynchronous active-low reset
//   audio_in   : square wave under measurement, asynchronous
//   enable     : measurement enable; low clears everything synchronously
//   hp_out     : last captured half-period, 0 when not valid
//   hp_valid   : hp_out holds a real measurement
//   locked     : last LOCK_COUNT captures were identical
//   sample_stb : one-cycle pulse on each capture
module freq_meter
  import freq_pkg::*;
#(
  parameter int unsigned HP_W        = HP_W_DEFAULT,
  parameter int unsigned LOCK_COUNT  = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            synth_clk,
  input  logic            rst_n,
  input  logic            audio_in,
  input  logic            enable,
  output logic [HP_W-1:0] hp_out,
  output logic            hp_valid,
  output logic            locked,
  output logic            sample_stb
);

  localparam int unsigned           CNT_W     = HP_W + 1;
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      HP_MAX    = CNT_W'((1 << HP_W) - 1);
  localparam logic [CNT_W-1:0]      TIMEOUT   = CNT_W'(1 << HP_W);
  localparam logic [MATCH_W-1:0]    MATCH_ONE = MATCH_W'(1);
  localparam logic [MATCH_W-1:0]    LOCK_THR  = MATCH_W'(LOCK_COUNT);

  logic edge_pulse;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic               valid_q, valid_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               locked_q, locked_d;
  logic               stb_q, stb_d;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .synth_clk (synth_clk),
    .rst_n     (rst_n),
    .clr       (~enable),
    .din       (audio_in),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    valid_d = valid_q;
    match_d = match_q;
    stb_d   = 1'b0;

    // cnt counts cycles since the last edge; it equals N at an edge N cycles on.
    if (edge_pulse) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (edge_pulse) state_d = MEASURE;
      end
      MEASURE, TRACK: begin
        if (edge_pulse) begin
          if (cnt_q <= HP_MAX) begin
            stb_d   = 1'b1;
            valid_d = 1'b1;
            state_d = TRACK;
            if (state_q == TRACK && cnt_q[HP_W-1:0] == hp_q) begin
              match_d = sat_inc(match_q);
            end else begin
              hp_d    = cnt_q[HP_W-1:0];
              match_d = MATCH_ONE;
            end
          end else begin
            // Too long to measure: this edge just becomes the new reference.
            state_d = MEASURE;
            hp_d    = '0;
            valid_d = 1'b0;
            match_d = '0;
          end
        end else if (cnt_q == TIMEOUT) begin
          state_d = IDLE;
          hp_d    = '0;
          valid_d = 1'b0;
          match_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    locked_d = valid_d && (match_d >= LOCK_THR);
  end

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ONE;
      hp_q     <= '0;
      valid_q  <= 1'b0;
      match_q  <= '0;
      locked_q <= 1'b0;
      stb_q    <= 1'b0;
    end else if (!enable) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ONE;
      hp_q     <= '0;
      valid_q  <= 1'b0;
      match_q  <= '0;
      locked_q <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      valid_q  <= valid_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      stb_q    <= stb_d;
    end
  end

  assign hp_out     = hp_q;
  assign hp_valid   = valid_q;
  assign locked     = locked_q;
  assign sample_stb = stb_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: square-wave tones driven on audio_in,
// every cycle compared against a timestamp-based reference model, plus
// directed checks of the capture/lock/timeout/reset behaviour.
module tb_freq_meter;

  localparam int unsigned HP_W        = 7;
  localparam int unsigned HP_MAX      = 127;
  localparam int unsigned LOCK_COUNT  = 3;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MATCH_SAT   = 15;
`ifdef FREQ_METER_DEGLITCH_EN
  localparam bit DEGLITCH = 1'b1;
`else
  localparam bit DEGLITCH = 1'b0;
`endif
  // Sample cycle of an input change to the cycle its capture is registered.
  localparam int unsigned LAT = SYNC_STAGES + 1 + (DEGLITCH ? 1 : 0);

  logic            synth_clk = 1'b0;
  logic            rst_n;
  logic            audio_in;
  logic            enable;
  logic [HP_W-1:0] hp_out;
  logic            hp_valid;
  logic            locked;
  logic            sample_stb;

  always #5 synth_clk = ~synth_clk;

  freq_meter #(
    .HP_W       (HP_W),
    .LOCK_COUNT (LOCK_COUNT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .synth_clk (synth_clk),
    .rst_n     (rst_n),
    .audio_in  (audio_in),
    .enable    (enable),
    .hp_out    (hp_out),
    .hp_valid  (hp_valid),
    .locked    (locked),
    .sample_stb(sample_stb)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edges are timestamps; a capture is the distance between
  // consecutive accepted edges if it fits in the code, otherwise the edge only
  // restarts the measurement. 128 cycles of silence forget everything.
  int unsigned cyc = 0;
  bit          m_prev_smp, m_acc, m_prev_acc;
  bit          m_line[$];
  bit          m_have_ref;
  int unsigned m_ref;
  int unsigned m_hp;
  bit          m_valid;
  int unsigned m_match;
  bit          m_stb;

  int log_hp[$];
  int log_lock[$];
  int log_t[$];

  function automatic bit m_locked();
    return m_valid && (m_match >= LOCK_COUNT);
  endfunction

  function automatic void model_clear();
    m_prev_smp = 1'b0;
    m_acc      = 1'b0;
    m_prev_acc = 1'b0;
    m_line.delete();
    for (int i = 0; i < int'(LAT); i++) m_line.push_back(1'b0);
    m_have_ref = 1'b0;
    m_ref      = 0;
    m_hp       = 0;
    m_valid    = 1'b0;
    m_match    = 0;
    m_stb      = 1'b0;
  endfunction

  function automatic void model_step(input bit smp);
    bit          e_new;
    bit          e;
    int unsigned gap;
    cyc++;
    // With deglitching a level counts only once seen on two samples in a row.
    if (!DEGLITCH || smp == m_prev_smp) m_acc = smp;
    m_prev_smp = smp;
    e_new      = m_acc ^ m_prev_acc;
    m_prev_acc = m_acc;
    m_line.push_back(e_new);
    e     = m_line.pop_front();
    m_stb = 1'b0;
    if (e) begin
      gap = cyc - m_ref;
      if (m_have_ref && gap <= HP_MAX) begin
        m_stb = 1'b1;
        if (m_valid && gap == m_hp) begin
          if (m_match < MATCH_SAT) m_match++;
        end else begin
          m_hp    = gap;
          m_match = 1;
        end
        m_valid = 1'b1;
      end else begin
        m_hp    = 0;
        m_valid = 1'b0;
        m_match = 0;
      end
      m_have_ref = 1'b1;
      m_ref      = cyc;
    end else if (m_have_ref && (cyc - m_ref) == HP_MAX + 1) begin
      m_have_ref = 1'b0;
      m_hp       = 0;
      m_valid    = 1'b0;
      m_match    = 0;
    end
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(posedge synth_clk);
    if (!rst_n || !enable) model_clear();
    else model_step(audio_in);
    #1;
  endtask

  task automatic clear_log();
    log_hp.delete();
    log_lock.delete();
    log_t.delete();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    audio_in = 1'b0;
    enable   = 1'b1;
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;
    clear_log();
  endtask

  // Toggle audio_in every hp cycles (hp=0: hold) and compare every cycle.
  task automatic run_tone(input int hp, input int n);
    int              ph;
    logic [HP_W-1:0] exp_hp;
    ph = 0;
    for (int i = 0; i < n; i++) begin
      if (hp > 0) begin
        ph++;
        if (ph >= hp) begin
          audio_in = ~audio_in;
          ph       = 0;
        end
      end
      tick();
      exp_hp = m_hp[HP_W-1:0];
      checks++;
      if ({hp_out, hp_valid, locked, sample_stb} !== {exp_hp, m_valid, m_locked(), m_stb}) begin
        errors++;
        $display("FAIL cycle_model hp=%0d i=%0d hp_out=%0d/%0d valid=%0b/%0b locked=%0b/%0b stb=%0b/%0b",
                 hp, i, hp_out, exp_hp, hp_valid, m_valid, locked, m_locked(), sample_stb, m_stb);
      end
      if (sample_stb === 1'b1) begin
        log_hp.push_back(int'(hp_out));
        log_lock.push_back(int'(locked));
        log_t.push_back(i);
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    audio_in = 1'b0;
    enable   = 1'b1;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({hp_out, hp_valid, locked, sample_stb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {hp_out, hp_valid, locked, sample_stb});
    end
    tick();
    rst_n = 1'b1;
    run_tone(0, 5);
  endtask

  task automatic test_tone10();
    do_reset();
    run_tone(10, 60);
    checks++;
    if (log_hp.size() != 4) begin
      errors++;
      $display("FAIL tone10_count got %0d want 4", log_hp.size());
    end
    checks++;
    if (at(log_t, 0) != 19 + int'(LAT)) begin
      errors++;
      $display("FAIL tone10_first_stb_time got %0d want %0d", at(log_t, 0), 19 + LAT);
    end
    checks++;
    if (at(log_hp, 0) != 10) begin
      errors++;
      $display("FAIL tone10_hp got %0d want 10", at(log_hp, 0));
    end
    checks++;
    if (at(log_lock, 1) != 0 || at(log_lock, 2) != 1) begin
      errors++;
      $display("FAIL tone10_lock got %0d,%0d want 0,1", at(log_lock, 1), at(log_lock, 2));
    end
  endtask

  task automatic test_tone1();
    do_reset();
    run_tone(1, 40);
`ifdef FREQ_METER_DEGLITCH_EN
    run_tone(1, 130);
    checks++;
    if (log_hp.size() != 0 || hp_valid !== 1'b0) begin
      errors++;
      $display("FAIL tone1_deglitch got count=%0d valid=%0b want 0,0", log_hp.size(), hp_valid);
    end
`else
    checks++;
    if (at(log_hp, 0) != 1 || at(log_t, 0) != 1 + int'(LAT)) begin
      errors++;
      $display("FAIL tone1_first got hp=%0d t=%0d want 1,%0d", at(log_hp, 0), at(log_t, 0),
               1 + LAT);
    end
    checks++;
    if (at(log_lock, 1) != 0 || at(log_lock, 2) != 1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL tone1_lock got %0d,%0d,%0b want 0,1,1", at(log_lock, 1), at(log_lock, 2),
               locked);
    end
`endif
  endtask

  task automatic test_switch();
    do_reset();
    run_tone(10, 60);
    clear_log();
    run_tone(20, 80);
    checks++;
    if (at(log_hp, 0) != 10 || at(log_lock, 0) != 1) begin
      errors++;
      $display("FAIL switch_tail got hp=%0d lock=%0d want 10,1", at(log_hp, 0), at(log_lock, 0));
    end
    checks++;
    if (at(log_hp, 1) != 20 || at(log_lock, 1) != 0) begin
      errors++;
      $display("FAIL switch_first20 got hp=%0d lock=%0d want 20,0", at(log_hp, 1),
               at(log_lock, 1));
    end
    checks++;
    if (at(log_hp, 3) != 20 || at(log_lock, 2) != 0 || at(log_lock, 3) != 1) begin
      errors++;
      $display("FAIL switch_relock got hp=%0d lock=%0d,%0d want 20,0,1", at(log_hp, 3),
               at(log_lock, 2), at(log_lock, 3));
    end
  endtask

  task automatic test_silence();
    do_reset();
    run_tone(10, 60);
    run_tone(0, int'(LAT) + 127);
    checks++;
    if (hp_valid !== 1'b1 || locked !== 1'b1 || hp_out !== 7'd10) begin
      errors++;
      $display("FAIL silence_before_timeout got valid=%0b locked=%0b hp=%0d want 1,1,10",
               hp_valid, locked, hp_out);
    end
    run_tone(0, 1);
    checks++;
    if (hp_valid !== 1'b0 || locked !== 1'b0 || hp_out !== 7'd0) begin
      errors++;
      $display("FAIL silence_timeout got valid=%0b locked=%0b hp=%0d want 0,0,0",
               hp_valid, locked, hp_out);
    end
    clear_log();
    run_tone(5, 30);
    checks++;
    if (at(log_t, 0) != 9 + int'(LAT) || at(log_hp, 0) != 5 || log_hp.size() != 4) begin
      errors++;
      $display("FAIL silence_resume got t=%0d hp=%0d n=%0d want %0d,5,4", at(log_t, 0),
               at(log_hp, 0), log_hp.size(), 9 + LAT);
    end
  endtask

  task automatic test_long_gap();
    do_reset();
    run_tone(130, 520);
    checks++;
    if (log_hp.size() != 0 || hp_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap130 got n=%0d valid=%0b want 0,0", log_hp.size(), hp_valid);
    end
    run_tone(128, 520);
    checks++;
    if (log_hp.size() != 0 || hp_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap128 got n=%0d valid=%0b want 0,0", log_hp.size(), hp_valid);
    end
    run_tone(127, 400);
    checks++;
    if (log_hp.size() != 2 || at(log_hp, 0) != 127) begin
      errors++;
      $display("FAIL gap127 got n=%0d hp=%0d want 2,127", log_hp.size(), at(log_hp, 0));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    run_tone(10, 60);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL areset_prelock got %0b want 1", locked);
    end
    #3 rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({hp_out, hp_valid, locked, sample_stb} !== '0) begin
      errors++;
      $display("FAIL areset_immediate got %h want 0", {hp_out, hp_valid, locked, sample_stb});
    end
    tick();
    rst_n = 1'b1;
    run_tone(0, 3);
  endtask

  task automatic test_enable();
    do_reset();
    run_tone(10, 60);
    checks++;
    if (locked !== 1'b1 || hp_valid !== 1'b1) begin
      errors++;
      $display("FAIL enable_prelock got locked=%0b valid=%0b want 1,1", locked, hp_valid);
    end
    enable = 1'b0;
    tick();
    checks++;
    if ({hp_out, hp_valid, locked, sample_stb} !== '0) begin
      errors++;
      $display("FAIL enable_clear got %h want 0", {hp_out, hp_valid, locked, sample_stb});
    end
    enable = 1'b1;
    clear_log();
    run_tone(10, 60);
    checks++;
    if (at(log_t, 0) != 19 + int'(LAT) || at(log_hp, 0) != 10 || at(log_lock, 0) != 0) begin
      errors++;
      $display("FAIL enable_remeasure got t=%0d hp=%0d lock=%0d want %0d,10,0", at(log_t, 0),
               at(log_hp, 0), at(log_lock, 0), 19 + LAT);
    end
  endtask

  task automatic test_random();
    int kind;
    int hp;
    do_reset();
    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        run_tone(0, $urandom_range(20, 200));
      end else if (kind == 1) begin
        enable = 1'b0;
        run_tone(0, 1);
        enable = 1'b1;
      end else if (kind == 2) begin
        hp = $urandom_range(120, 135);
        run_tone(hp, hp * 3);
      end else begin
        hp = $urandom_range(1, 24);
        run_tone(hp, hp * $urandom_range(2, 8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_tone10();
    test_tone1();
    test_switch();
    test_silence();
    test_long_gap();
    test_async_reset();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Receive-side counterpart of the square-wave tone generator.
- Samples an incoming audio square wave, measures its half-period in synth_clk cycles, and reports it as an HP_W-bit half-period code.
- The code uses the same encoding the generator consumes, so a generator driven with hp=N reads back N.
- Used for tone detection/loopback checking and sits next to the synth in the audio path.

Parameters:
- HP_W, 7, width of the half-period code; HP_MAX = 2**HP_W-1.
- LOCK_COUNT, 3, number of consecutive identical captures required to assert locked (range 1..15).
- SYNC_STAGES, 2, synchronizer flops on audio_in (minimum 2).

Ports:
- synth_clk  input  1  block clock.
- rst_n  input  1  reset, asynchronous assert, active-low; clears all state.
- audio_in  input  1  square wave under measurement, asynchronous to synth_clk.
- enable  input  1  measurement enable; low gives a synchronous clear to IDLE.
- hp_out  output  HP_W  last captured half-period; 0 when not valid.
- hp_valid  output  1  hp_out holds a real measurement.
- locked  output  1  the last LOCK_COUNT captures were identical.
- sample_stb  output  1  one-cycle pulse on each capture.

Behaviour:
- Reset (rst_n low, asynchronous) and enable low (synchronous) have the same effect:
  - state IDLE;
  - hp_out=0, hp_valid=0, locked=0, sample_stb=0;
  - cnt=1, match=0;
  - synchronizer flops cleared to 0.
- Front end:
  - audio_in passes through SYNC_STAGES flops, then one history flop.
  - edge = synced level XOR history.
  - Both rising and falling edges count.
- Counter cnt, HP_W+1 bits:
  - on edge, cnt<=1;
  - otherwise cnt<=cnt+1, saturating at all-ones.
  - A tone with half-period N produces edges N cycles apart, so cnt==N at the second edge.
- States:
  - IDLE: no reference edge. On edge -> MEASURE.
  - MEASURE: reference edge seen, no capture yet.
    - On edge with 1<=cnt<=HP_MAX: capture; hp_out<=cnt, hp_valid<=1, match<=1, sample_stb pulse -> TRACK.
  - TRACK: on edge with cnt<=HP_MAX:
    - capture, sample_stb pulse;
    - if cnt==hp_out, match<=match+1 (saturating);
    - else hp_out<=cnt and match<=1.
- locked = hp_valid && match>=LOCK_COUNT, registered together with the capture.
  - On a mismatching capture, locked drops in the same cycle the new hp_out appears.
- Timeout/silence: in MEASURE or TRACK, when cnt==HP_MAX+1 and there is no edge:
  - -> IDLE on the next clock;
  - hp_out=0, hp_valid=0, locked=0.
- Edge coinciding with cnt>HP_MAX: edge takes priority over timeout.
  - The measurement is discarded (no strobe).
  - The edge becomes the new reference; state -> MEASURE, outputs cleared.
- Latency: a transition on audio_in setting up before clock edge t gives sample_stb/hp_out at t+SYNC_STAGES+1.
- Minimum measurable half-period is 1 (toggle every cycle); hp_out=0 is never produced as a valid value.
- The first edge after reset, enable, or timeout never produces a capture.

Optional Feature:
- Macro: FREQ_METER_DEGLITCH_EN.
- Defined:
  - A deglitch stage follows the synchronizer.
  - A new level is accepted only after two consecutive identical synced samples.
  - Adds exactly 1 cycle of latency; measured values for half-periods >=2 are unchanged.
  - Single-cycle pulses are rejected.
  - A half-period-1 tone yields no accepted edges and therefore times out to IDLE.
- Undefined: no deglitch stage; behaviour exactly as above.

Decomposition:
- Package freq_pkg: HP_W default, HP_MAX, state enum {IDLE, MEASURE, TRACK}, and the match counter width.
- One sub-module, sync_edge_det:
  - contains the synchronizer, the optional deglitch stage, the history flop and the edge pulse;
  - also has async active-low reset.
- Counter, FSM and output registers live in freq_meter.

Test Plan:
- Synth at hp=10 drives audio_in -> no strobe on the 1st edge; strobe with hp_out=10, hp_valid=1 on the 2nd edge; locked=1 on the 3rd capture (4th edge).
- Synth at hp=1 -> hp_out=1, locked after 3 captures. With FREQ_METER_DEGLITCH_EN: no strobe, IDLE after 128 cycles.
- Switch hp 10->20 mid-stream -> next capture is 20 with locked=0 in the same cycle; locked re-asserts on the 3rd consecutive capture of 20.
- Stop toggling after lock -> 128 cycles after the last synced edge, hp_valid=0, locked=0, hp_out=0, state IDLE. Then resume hp=5 -> first strobe on the 2nd edge.
- Edges 130 cycles apart -> no strobe ever, hp_valid stays 0.
- rst_n pulsed low between clock edges while locked -> all outputs 0 immediately without a clock.
- enable low for 1 cycle -> outputs 0 at the next edge, and re-measurement needs two edges.
